// File: rtl/wb_pkg.sv
// wb_pkg: shared source indices, state encoding and default parameters for the write-back stage
package wb_pkg;
  localparam int SRC_ULA   = 0;
  localparam int SRC_MEM   = 1;
  localparam int SRC_INPUT = 2;
  localparam int SRC_HD    = 3;
  localparam int SRC_PC    = 4;
  localparam int WB_DATA_W      = 32;
  localparam int WB_NUM_SRC     = 5;
  localparam int WB_SEL_W       = 3;
  localparam int WB_DEST_W      = 5;
  localparam int WB_DEFAULT_SRC = SRC_PC;
  localparam int WB_TIMEOUT     = 255;
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} wb_state_t;
endpackage

// File: rtl/wb_select_stage.sv
// wb_select_stage: registered write-back source selector with stall on slow sources and timeout abort
module wb_select_stage
  import wb_pkg::*;
#(
  parameter int DATA_W      = WB_DATA_W,
  parameter int NUM_SRC     = WB_NUM_SRC,
  parameter int SEL_W       = WB_SEL_W,
  parameter int DEST_W      = WB_DEST_W,
  parameter int DEFAULT_SRC = WB_DEFAULT_SRC,
  parameter int TIMEOUT     = WB_TIMEOUT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_SRC*DATA_W-1:0] dado_src,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [SEL_W-1:0]          controle,
  input  logic                      req,
  input  logic [DEST_W-1:0]         reg_dest,
  input  logic                      erro_clr,
  output logic [DATA_W-1:0]         saida,
  output logic [DEST_W-1:0]         reg_dest_out,
  output logic                      escreve,
  output logic                      ocupado,
  output logic                      erro
);
  localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  wb_state_t state, state_n;
  logic [SEL_W-1:0] sel, sel_q, src;
  logic [CW-1:0] cnt;
  logic load, start, abort;
  assign sel = (int'(controle) < NUM_SRC) ? controle : SEL_W'(DEFAULT_SRC);
  // decide this cycle's action: immediate write, enter wait, finish wait, or abort
  always_comb begin
    state_n = state;
    load = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    src = (state == WAIT) ? sel_q : sel;
    if (state == IDLE) begin
      if (req && src_valid[sel]) load = 1'b1;
      else if (req) begin
        start = 1'b1;
        state_n = WAIT;
      end
    end else if (src_valid[sel_q]) begin
      load = 1'b1;
      state_n = IDLE;
    end else if (TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1)) begin
      abort = 1'b1;
      state_n = IDLE;
    end
  end
  // state register
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  // output, latch and timeout-counter registers
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      saida <= '0;
      reg_dest_out <= '0;
      escreve <= 1'b0;
      ocupado <= 1'b0;
      erro <= 1'b0;
      cnt <= '0;
      sel_q <= '0;
    end else begin
      escreve <= load;
      ocupado <= (state_n == WAIT);
      erro <= abort | (erro & ~erro_clr);
      if (load) saida <= dado_src[int'(src)*DATA_W +: DATA_W];
      if (state == IDLE && req) reg_dest_out <= reg_dest;
      if (start) sel_q <= sel;
      cnt <= start ? '0 : (state == WAIT && !load && !abort && TIMEOUT != 0) ? cnt + 1'b1 : cnt;
    end
endmodule
